// File: rtl/pipe_pkg.sv
// Shared pipeline types for hazard detection and forwarding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: stage_tag_t (valid, regwr, dst, is_load), BUBBLE, REG_ZERO and
// a tag builder. Tag register fields are TAG_W wide so any NUM_REGS up to
// 2**TAG_W can share the same struct; narrower register numbers are
// zero-extended into it.
package pipe_pkg;

  localparam int TAG_W = 8;

  typedef struct packed {
    logic             valid;
    logic             regwr;
    logic [TAG_W-1:0] dst;
    logic             is_load;
  } stage_tag_t;

  localparam stage_tag_t       BUBBLE   = '0;
  localparam logic [TAG_W-1:0] REG_ZERO = '0;

  function automatic stage_tag_t make_tag(input logic             valid,
                                          input logic             regwr,
                                          input logic [TAG_W-1:0] dst,
                                          input logic             is_load);
    stage_tag_t t;
    t.valid   = valid;
    t.regwr   = regwr;
    t.dst     = dst;
    t.is_load = is_load;
    return t;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_src_match.sv
// Compares one ID source operand against one shadow-stage tag.
// Latency: combinational.
// Backpressure: none.
//
// Ports: src/used = operand register and read-enable; tag = producer stage;
// hit = producer writes this operand; hit_load = hit by a load.
module src_match
  import pipe_pkg::*;
(
  input  logic [TAG_W-1:0] src,
  input  logic             used,
  input  stage_tag_t       tag,
  output logic             hit,
  output logic             hit_load
);

  // Register 0 is hard-wired, so a write to it never produces a dependency.
  assign hit      = used && tag.valid && tag.regwr &&
                    (tag.dst != REG_ZERO) && (tag.dst == src);
  assign hit_load = hit && tag.is_load;

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, flush/freeze control and forwarding selects for a 5-stage pipe.
// Latency: stall_id/bubble_ex combinational; forward selects and stall_count registered (1 cycle).
// Backpressure: mem_wait freezes all state and holds the front end; load-use holds ID for one cycle.
//
// Ports: clk/rst (sync, active-high); id_* = decoded ID instruction;
// flush kills the ID instruction; mem_wait freezes the pipe;
// stall_id/bubble_ex drive fetch hold and ID/EX nop insertion;
// ex_forward/mem_forward select per-operand bypass in EX; stall_count counts
// load-use stall cycles.
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NUM_SRC*$clog2(NUM_REGS)-1:0] id_src,
  input  logic [NUM_SRC-1:0]             id_src_used,
  input  logic [$clog2(NUM_REGS)-1:0]    id_dst,
  input  logic                           id_regwr,
  input  logic                           id_is_load,
  input  logic                           flush,
  input  logic                           mem_wait,
  output logic                           stall_id,
  output logic                           bubble_ex,
  output logic [NUM_SRC-1:0]             ex_forward,
  output logic [NUM_SRC-1:0]             mem_forward,
  output logic [CNT_W-1:0]               stall_count
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int EX    = 0;
  localparam int MEM   = 1;
  localparam int WB    = 2;

  // Shadow tags of the instructions in EX, MEM and WB.
  stage_tag_t stage_q [3];
  stage_tag_t id_tag;

  // hit[s][k]: operand k depends on stage s (0 = EX, 1 = MEM).
  logic hit    [2][NUM_SRC];
  logic hit_ld [2][NUM_SRC];

  logic [NUM_SRC-1:0] ex_hit;
  logic [NUM_SRC-1:0] mem_hit;
  logic [NUM_SRC-1:0] ex_hit_ld;
  logic               load_use;

  for (genvar s = 0; s < 2; s++) begin : g_stage
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      src_match u_src_match (
        .src      (TAG_W'(id_src[k*REG_W +: REG_W])),
        .used     (id_src_used[k]),
        .tag      (stage_q[s]),
        .hit      (hit[s][k]),
        .hit_load (hit_ld[s][k])
      );
    end
  end

  always_comb begin
    ex_hit    = '0;
    mem_hit   = '0;
    ex_hit_ld = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      ex_hit[k]    = hit[EX][k];
      mem_hit[k]   = hit[MEM][k];
      ex_hit_ld[k] = hit_ld[EX][k];
    end
  end

  assign load_use = id_valid && (|ex_hit_ld);

  always_comb begin
    id_tag = BUBBLE;
    if (id_valid) begin
      id_tag = make_tag(1'b1, id_regwr, TAG_W'(id_dst), id_is_load);
    end
  end

  // Freeze dominates; a flush kills the ID instruction so it can never stall.
  assign stall_id  = mem_wait || (!flush && load_use);
  assign bubble_ex = !mem_wait && (flush || load_use);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) stage_q[s] <= BUBBLE;
      ex_forward  <= '0;
      mem_forward <= '0;
      stall_count <= '0;
    end else if (mem_wait) begin
      // Hold everything; the hazard is re-evaluated after release.
    end else begin
      stage_q[WB]  <= stage_q[MEM];
      stage_q[MEM] <= stage_q[EX];
      if (flush || load_use) begin
        stage_q[EX] <= BUBBLE;
        ex_forward  <= '0;
        mem_forward <= '0;
        if (!flush) begin
          stall_count <= stall_count + CNT_W'(1);
        end
      end else begin
        stage_q[EX] <= id_tag;
        ex_forward  <= ex_hit;
        // The youngest producer (EX) wins over MEM.
        mem_forward <= mem_hit & ~ex_hit;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_dst;
  logic        id_regwr;
  logic        id_is_load;
  logic        flush;
  logic        mem_wait;
  logic        stall_id;
  logic        bubble_ex;
  logic [1:0]  ex_forward;
  logic [1:0]  mem_forward;
  logic [31:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [1:0]  exf;
    logic [1:0]  memf;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .NUM_REGS (32),
    .NUM_SRC  (2),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dst      (id_dst),
    .id_regwr    (id_regwr),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .mem_wait    (mem_wait),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .ex_forward  (ex_forward),
    .mem_forward (mem_forward),
    .stall_count (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One pipeline cycle: drive ID/control, check the combinational outputs at
  // the falling edge, push the registered outputs expected after the rising
  // edge, then pop and compare them once the edge has passed.
  task automatic cyc(input string tag,
                     input logic v, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] used, input logic [4:0] d,
                     input logic wr, input logic ld,
                     input logic fl, input logic mw, input logic r,
                     input logic e_st, input logic e_bb,
                     input logic [1:0] e_exf, input logic [1:0] e_memf,
                     input logic [31:0] e_cnt);
    exp_t e;
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_dst      = d;
    id_regwr    = wr;
    id_is_load  = ld;
    flush       = fl;
    mem_wait    = mw;
    rst         = r;
    @(negedge clk);
    if (!r) begin
      chk({tag, ".stall_id"},  32'(stall_id),  32'(e_st));
      chk({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(e_bb));
    end
    e.tag  = tag;
    e.exf  = e_exf;
    e.memf = e_memf;
    e.cnt  = e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".ex_forward"},  32'(ex_forward),  32'(e.exf));
      chk({e.tag, ".mem_forward"}, 32'(mem_forward), 32'(e.memf));
      chk({e.tag, ".stall_count"}, stall_count,      e.cnt);
    end
  endtask

  task automatic nop(input string tag, input logic [31:0] cnt);
    cyc(tag, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
  endtask

  task automatic drain(input string tag, input logic [31:0] cnt);
    for (int i = 0; i < 3; i++) nop(tag, cnt);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0;
    id_regwr = 0; id_is_load = 0; flush = 0; mem_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.stall_id",    32'(stall_id),    32'd0);
    chk("reset.bubble_ex",   32'(bubble_ex),   32'd0);
    chk("reset.ex_forward",  32'(ex_forward),  32'd0);
    chk("reset.mem_forward", 32'(mem_forward), 32'd0);
    chk("reset.stall_count", stall_count,      32'd0);
    @(posedge clk);
    #1;

    // addi $1,$0,2015; addi $2,$0,404; add $1,$1,$2
    cyc("fwd.addi1", 1, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("fwd.addi2", 1, 0, 0, 2'b01, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("fwd.add",   1, 1, 2, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0);
    drain("fwd.nop", 0);

    // lw $3,0($0); add $5,$3,$3
    cyc("lu.lw",       1, 0, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("lu.add_stall",1, 3, 3, 2'b11, 5, 1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1);
    cyc("lu.add_go",   1, 3, 3, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1);
    drain("lu.nop", 1);

    // addi $0,$0,7; add $4,$0,$0
    cyc("r0.addi0", 1, 0, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc("r0.add",   1, 0, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    drain("r0.nop", 1);

    // lw $3; mem_wait 3 cycles with add $6,$3,$0 waiting in ID
    cyc("mw.lw", 1, 0, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    for (int i = 0; i < 3; i++)
      cyc("mw.freeze", 1, 3, 0, 2'b11, 6, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    cyc("mw.stall", 1, 3, 0, 2'b11, 6, 1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2);
    cyc("mw.go",    1, 3, 0, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2);
    drain("mw.nop", 2);

    // lw $3 then a dependent add killed by flush
    cyc("fl.lw",    1, 0, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2);
    cyc("fl.flush", 1, 3, 3, 2'b11, 5, 1, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2);
    drain("fl.nop", 2);

    // lw $1; reset during the load-use stall; add $5,$1,$0 gets no forward
    cyc("rs.lw",    1, 0, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2);
    cyc("rs.reset", 1, 1, 1, 2'b11, 5, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("rs.add5",  1, 1, 0, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("rs.add6",  1, 5, 0, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    drain("rs.nop", 0);

    chk("scoreboard.leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard-detection and forwarding controller for the 5-stage pipelined datapath. It tracks the destination tags of the instructions in EX, MEM and WB, and generates `ex_forward_*`/`mem_forward_*` selects aligned to the consumer's EX cycle. It also raises load-use stalls, handles branch/jump flushes and memory wait-state freezes, and counts stall cycles. It sits beside the decode stage and drives the datapath's forwarding muxes and the fetch unit's hold input.

## Interface
- `NUM_REGS`, 32: architectural registers; `REG_W = $clog2(NUM_REGS)`.
- `NUM_SRC`, 2: source operands per instruction (bit 0 = Rs/A, bit 1 = Rt/B).
- `CNT_W`, 32: stall-counter width.

- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  real instruction in ID.
- `id_src`  in  NUM_SRC*REG_W  source register numbers; slice k = operand k.
- `id_src_used`  in  NUM_SRC  operand k actually read.
- `id_dst`  in  REG_W  destination register (after RegDst mux).
- `id_regwr`  in  1  instruction writes `id_dst`.
- `id_is_load`  in  1  instruction is lw (MemToReg).
- `flush`  in  1  taken branch/jump resolved; kill the ID instruction.
- `mem_wait`  in  1  data memory not ready; freeze the whole pipeline.
- `stall_id`  out  1  hold PC and IF/ID (combinational).
- `bubble_ex`  out  1  load nop into ID/EX (combinational).
- `ex_forward`  out  NUM_SRC  operand k takes the EX/MEM ALU result (registered).
- `mem_forward`  out  NUM_SRC  operand k takes the MEM/WB write-back value (registered).
- `stall_count`  out  CNT_W  count of load-use stall cycles (registered).

## Operation
- Shadow stages `ex_q`, `mem_q`, `wb_q` each hold {valid, regwr, dst, is_load}.
- A producer matches operand k only if: valid, regwr=1, dst≠0, dst==src[k] and `id_src_used[k]` set.
- Load-use hazard: `id_valid` with any operand matching `ex_q` while `ex_q.is_load`=1.
- Per-cycle priority, highest first:
  - `rst`: all stages invalid; `ex_forward`, `mem_forward` and `stall_count` cleared to 0.
  - `mem_wait`: all state and outputs hold; `stall_id`=1; `bubble_ex`=0; counter holds.
  - `flush`: `ex_q` becomes a bubble; mem_q←ex_q; wb_q←mem_q; forwards cleared; `bubble_ex`=1; `stall_id`=0.
  - Load-use: `ex_q` becomes a bubble and the other stages shift; forwards cleared; `stall_id`=1; `bubble_ex`=1; `stall_count`+1.
  - Otherwise: ex_q←ID fields (a bubble if `id_valid`=0); mem_q←ex_q; wb_q←mem_q.
- Forward selects in the "otherwise" case, per operand k:
  - `ex_forward[k]` = match against current `ex_q`.
  - `mem_forward[k]` = match against current `mem_q` and not against `ex_q`. The youngest producer wins.
- WB producers need no forwarding. The register file is write-through, so a read in the same cycle as a WB write returns the new value.
- Register 0 is never forwarded and never causes a stall.
- `stall_count` wraps modulo 2^CNT_W.

## Timing
- `stall_id` and `bubble_ex` are combinational from ID inputs and `ex_q`, valid in the same cycle.
- Forward selects have 1-cycle latency: computed while the consumer is in ID, registered on the edge it enters EX, and valid throughout its EX cycle.
- A load-use stall lasts exactly one cycle. Next cycle the load sits in `mem_q` and the consumer gets `mem_forward`.
- `mem_wait` during a load-use cycle: freeze wins. The hazard re-evaluates after release and the counter increments only once.
- `flush` together with a load-use hazard: flush wins and the counter does not increment.
- `rst` mid-stall: all outputs return to 0 on that edge.

## Structure
- Shared package `pipe_pkg`:
  - `stage_tag_t` struct {valid, regwr, dst, is_load};
  - `BUBBLE` constant (all zero);
  - `REG_ZERO` constant.
- One sub-module, `src_match`: combinational comparator of one source operand against one `stage_tag_t`. It is instantiated NUM_SRC×2 times.
- The state register, priority logic and counter live in the top module.

## Test plan
- addi $1,$0,2015; addi $2,$0,404; add $1,$1,$2 -> add in EX with `ex_forward`=2'b10 and `mem_forward`=2'b01. `stall_count`=0.
- lw $3,0($0); add $5,$3,$3 -> `stall_id`=`bubble_ex`=1 for one cycle, then `mem_forward`=2'b11; `stall_count`=1.
- addi $0,$0,7; add $4,$0,$0 -> no stall, forwards 0.
- lw $3; `mem_wait`=1 for 3 cycles; add $6,$3,$0 -> stages frozen 3 cycles, then a single 1-cycle stall; `stall_count`=1.
- lw $3 with `flush`=1 and dependent add in ID -> `bubble_ex`=1, `stall_id`=0, `stall_count` unchanged.
- Assert `rst` during a load-use stall -> next cycle all outputs 0; the following add $5,$1,$0 receives no forwarding.
